store_unit: RTL and testbench
=============================

# store_unit

Multi-cycle store sequencer between the register bank's B operand and the word-addressed data memory. It performs sw, sh and sb. sh and sb need a read-modify-write: the unit reads the addressed word, merges the selected byte or halfword lane, and writes the word back. The main control FSM issues a one-cycle start and waits for done before leaving the store state. The unit drives the memory port only while busy; the control FSM owns the port otherwise.

## Interface
- No parameters; all widths fixed at 32 bits.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- start  input  1  one-cycle request; sampled only in IDLE
- size  input  2  00 word, 01 halfword, 10 byte, 11 invalid
- addr  input  32  byte address (ALUOut); sampled with start
- data_in  input  32  store data (register B); sampled with start
- mem_rdata  input  32  memory read data, valid one cycle after address presented with mem_we=0
- mem_addr  output  32  word-aligned address {addr_q[31:2],2'b00}
- mem_wdata  output  32  write data
- mem_we  output  1  memory write enable
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse on successful completion
- err  output  1  one-cycle pulse on misaligned or invalid request; no write performed

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE with start=1: register addr_q, size_q and data_q, then check alignment:
  - size=11 → err.
  - size=00 with addr[1:0]≠0 → err.
  - size=01 with addr[0]=1 → err.
- On err: pulse err next cycle, stay in IDLE, mem_we stays 0.
- Valid word: IDLE→WRITE. mem_wdata=data_q.
- Valid half/byte path:
  - IDLE→READ. Drive mem_addr with mem_we=0.
  - READ→WAIT. mem_rdata valid in WAIT.
  - At the end of WAIT, latch the merged word into wbuf, then go to WRITE.
- Lane numbering is little-endian: byte lane k = bits [8k+7:8k].
  - Byte: lane addr[1:0] gets data_q[7:0].
  - Half: lane pair addr[1] gets data_q[15:0]: bits [15:0] if addr[1]=0, bits [31:16] if addr[1]=1.
  - All other bits come from mem_rdata unchanged.
- WRITE: mem_we=1, mem_wdata=wbuf (word path: data_q), mem_addr held. Next state DONE.
- DONE: done=1, mem_we=0. Next state IDLE.
- start while busy is ignored; it is not queued.
- mem_addr and mem_wdata hold their last values in IDLE.
- mem_we=1 only in WRITE, exactly one cycle per valid request.

## Timing
- Reset values: state IDLE, mem_addr 0, mem_wdata 0, mem_we 0, busy 0, done 0, err 0, internal registers 0. Reset takes effect immediately (asynchronous), regardless of clock.
- All outputs are registered or decoded from the state register. No combinational path from inputs to outputs.
- Latency, counting start sampled at edge 0:
  - sw: WRITE in cycle 1, done in cycle 2.
  - sh/sb: READ cycle 1, WAIT cycle 2, WRITE cycle 3, done in cycle 4.
  - err: pulse in cycle 1.
- Back-to-back requests: the earliest next start is the cycle after done (IDLE). Minimum period is 3 cycles for sw and 5 cycles for sh/sb.
- Reset mid-operation, including in WRITE: mem_we drops asynchronously, no done is issued, and the memory word is left as-is. A reset asserted during WRITE coincident with the clock edge must not commit a write attributed to the unit after deassertion.
- mem_rdata is sampled only at the end of WAIT; its value in any other cycle is don't-care.

## Test plan
- sw: addr=0x0000_0010, data_in=0xDEADBEEF → mem_we=1 in cycle 1 with mem_addr=0x10 and mem_wdata=0xDEADBEEF; done in cycle 2; busy high in cycles 1–2.
- sb all lanes: memory word 0x11223344, data_in=0xFFFF_FFAA, addr=0x20..0x23 → writes 0x112233AA, 0x1122AA44, 0x11AA3344, 0xAA223344; done in cycle 4 each.
- sh: word 0x11223344, data_in=0x0000_BEEF. addr=0x30 → 0x1122BEEF; addr=0x32 → 0xBEEF3344.
- Errors:
  - sw addr=0x41 → err in cycle 1, no mem_we.
  - sh addr=0x43 → err.
  - size=11 → err.
  - Unit accepts next start the following cycle.
- start pulsed during WAIT of an sb → ignored: exactly one write and one done.
- reset asserted during READ and during WRITE → all outputs 0 immediately. The next sw after reset release completes normally in 2 cycles.

Source files
------------

// File: rtl/store_unit.sv
// store_unit: multi-cycle store sequencer for sw/sh/sb into a word-addressed
// data memory. Word stores write directly; halfword/byte stores read the
// addressed word, merge the selected lane(s) and write the word back.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      one-cycle request, sampled only in IDLE
//   size       00 word, 01 halfword, 10 byte, 11 invalid
//   addr       byte address, sampled with start
//   data_in    store data, sampled with start
//   mem_rdata  memory read data, valid one cycle after the address is presented
//   mem_addr   word-aligned memory address
//   mem_wdata  memory write data
//   mem_we     memory write enable, high for exactly one cycle per valid request
//   busy       high in every state except IDLE
//   done       one-cycle pulse on successful completion
//   err        one-cycle pulse on a misaligned or invalid request
module store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 16;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state;
    state_t              stateNext;

    logic [DATA_W-1:0]   addrQ;
    logic [1:0]          sizeQ;
    logic [HALF_W-1:0]   dataQ;
    logic [DATA_W-1:0]   wbuf;
    logic                errQ;

    logic                reqBad;
    logic                accept;
    logic                reject;
    logic [DATA_W-1:0]   mergedWord;

    // Replace the addressed byte or halfword lane of the read word.
    function automatic logic [DATA_W-1:0] mergeLane(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        lane,
        input logic              isByte,
        input logic [HALF_W-1:0] data
    );
        logic [DATA_W-1:0] res;
        res = word;
        if (isByte) begin
            res[{lane, 3'b000} +: 8] = data[7:0];
        end else begin
            res[{lane[1], 4'b0000} +: HALF_W] = data;
        end
        return res;
    endfunction

    // Alignment / encoding check on the incoming request.
    always_comb begin
        reqBad = 1'b0;
        case (size)
            SIZE_WORD: reqBad = (addr[1:0] != 2'b00);
            SIZE_HALF: reqBad = addr[0];
            SIZE_BYTE: reqBad = 1'b0;
            SIZE_BAD:  reqBad = 1'b1;
            default:   reqBad = 1'b1;
        endcase
    end

    assign accept = (state == IDLE) && start && !reqBad;
    assign reject = (state == IDLE) && start && reqBad;

    assign mergedWord = mergeLane(mem_rdata, addrQ[1:0], (sizeQ == SIZE_BYTE), dataQ);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = (size == SIZE_WORD) ? WRITE : READ;
                end
            end
            READ:    stateNext = WAIT;
            WAIT:    stateNext = WRITE;
            WRITE:   stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Request capture, write buffer and error pulse. Captures only happen on
    // accepted requests so the memory port holds its last values in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addrQ <= '0;
            sizeQ <= '0;
            dataQ <= '0;
            wbuf  <= '0;
            errQ  <= 1'b0;
        end else begin
            errQ <= reject;
            if (accept) begin
                addrQ <= addr;
                sizeQ <= size;
                dataQ <= data_in[HALF_W-1:0];
                if (size == SIZE_WORD) begin
                    wbuf <= data_in;
                end
            end
            // mem_rdata is only meaningful at the end of WAIT.
            if (state == WAIT) begin
                wbuf <= mergedWord;
            end
        end
    end

    // Outputs come from registers or a decode of the state register only.
    assign mem_addr  = {addrQ[DATA_W-1:2], 2'b00};
    assign mem_wdata = wbuf;
    assign mem_we    = (state == WRITE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign err       = errQ;

endmodule

// File: tb/tb_store_unit.sv
// Testbench for store_unit: directed vector table, reset corner cases and
// randomized requests checked against a byte-level reference memory.
module tb_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    store_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .size      (size),
        .addr      (addr),
        .data_in   (data_in),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Data memory: 64 words, registered read, plus a bench-side poke port.
    logic [31:0] mem [0:63];
    logic        pokeEn;
    logic [5:0]  pokeIdx;
    logic [31:0] pokeVal;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end else if (pokeEn) begin
            mem[pokeIdx] <= pokeVal;
        end
        mem_rdata <= mem[mem_addr[7:2]];
    end

    // Reference memory contents as the bench expects them.
    logic [31:0] refMem [0:63];

    int nCmp = 0;
    int nBad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference rules.
    function automatic bit refBad(input logic [1:0] s, input logic [31:0] a);
        return (s == 2'b11) || (s == 2'b00 && a[1:0] != 2'b00) || (s == 2'b01 && a[0]);
    endfunction

    function automatic logic [31:0] refMerge(input logic [1:0] s, input logic [31:0] a,
                                             input logic [31:0] d, input logic [31:0] old);
        logic [31:0] res;
        res = 32'h0;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] ob;
            logic [7:0] nb;
            ob = 8'(old >> (8 * k));
            nb = ob;
            if (s == 2'b00) nb = 8'(d >> (8 * k));
            else if (s == 2'b01 && (k / 2) == int'(a[1])) nb = 8'(d >> (8 * (k % 2)));
            else if (s == 2'b10 && k == int'(a[1:0])) nb = d[7:0];
            res = res | (32'(nb) << (8 * k));
        end
        return res;
    endfunction

    function automatic int refLat(input logic [1:0] s, input logic [31:0] a);
        if (refBad(s, a)) return 1;
        return (s == 2'b00) ? 2 : 4;
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic poke(input int idx, input logic [31:0] v);
        pokeEn  = 1'b1;
        pokeIdx = 6'(idx);
        pokeVal = v;
        @(posedge clk); #1;
        pokeEn = 1'b0;
        refMem[idx] = v;
    endtask

    task automatic doReq(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                         input bit hitBusy,
                         output int lat, output int weCount, output int weCycle,
                         output logic [31:0] weAddr, output logic [31:0] weData,
                         output bit sawErr, output bit busy1, output int postDone);
        start   = 1'b1;
        size    = s;
        addr    = a;
        data_in = d;
        @(posedge clk); #1;
        start    = 1'b0;
        lat      = 0;
        weCount  = 0;
        weCycle  = 0;
        weAddr   = 32'h0;
        weData   = 32'h0;
        sawErr   = 1'b0;
        busy1    = busy;
        postDone = 0;
        for (int c = 1; c <= 8; c++) begin
            // A stray start while busy must be dropped.
            if (hitBusy && c == 2) begin
                start   = 1'b1;
                size    = 2'b00;
                addr    = 32'h0000_00F0;
                data_in = 32'h5555_5555;
            end
            if (mem_we) begin
                weCount++;
                if (weCycle == 0) begin
                    weCycle = c;
                    weAddr  = mem_addr;
                    weData  = mem_wdata;
                end
            end
            if (err) sawErr = 1'b1;
            if (done || err) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (lat != 0 && !sawErr) begin
            @(posedge clk); #1;
            start = 1'b0;
            postDone = int'(done) + int'(mem_we) + int'(busy);
        end
        start = 1'b0;
    endtask

    task automatic applyAndCheck(input string tag, input logic [1:0] s, input logic [31:0] a,
                                 input logic [31:0] d, input bit hitBusy,
                                 input logic [31:0] expWord, input bit expErr, input int expLat);
        int          lat;
        int          weCount;
        int          weCycle;
        logic [31:0] weAddr;
        logic [31:0] weData;
        bit          sawErr;
        bit          busy1;
        int          postDone;
        int          idx;
        idx = int'(a[7:2]);
        doReq(s, a, d, hitBusy, lat, weCount, weCycle, weAddr, weData, sawErr, busy1, postDone);
        check({tag, " latency"}, 32'(lat), 32'(expLat));
        check({tag, " err"}, 32'(sawErr), 32'(expErr));
        check({tag, " writes"}, 32'(weCount), expErr ? 32'd0 : 32'd1);
        check({tag, " busy1"}, 32'(busy1), expErr ? 32'd0 : 32'd1);
        if (!expErr) begin
            check({tag, " weCycle"}, 32'(weCycle), 32'(expLat - 1));
            check({tag, " weAddr"}, weAddr, {a[31:2], 2'b00});
            check({tag, " weData"}, weData, expWord);
            check({tag, " idle after"}, 32'(postDone), 32'd0);
        end
        check({tag, " memword"}, mem[idx], expWord);
        refMem[idx] = expWord;
    endtask

    typedef struct {
        logic [1:0]  s;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] pre;
        logic [31:0] exp;
        bit          e;
        int          lat;
        bit          hit;
        bit          doPoke;
    } vec_t;

    vec_t tbl [0:14];

    task automatic resetMidOp(input string tag, input logic [1:0] s, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] pre, input int atCycle);
        int idx;
        int seen;
        idx = int'(a[7:2]);
        poke(idx, pre);
        start   = 1'b1;
        size    = s;
        addr    = a;
        data_in = d;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < atCycle; c++) begin
            @(posedge clk); #1;
        end
        if (atCycle == 1 && s == 2'b00) check({tag, " we before reset"}, 32'(mem_we), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check({tag, " ctrl in reset"}, {28'h0, busy, mem_we, done, err}, 32'h0);
        check({tag, " addr in reset"}, mem_addr, 32'h0);
        check({tag, " wdata in reset"}, mem_wdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            seen += int'(done) + int'(mem_we) + int'(busy);
            @(posedge clk); #1;
        end
        check({tag, " quiet after reset"}, 32'(seen), 32'd0);
        check({tag, " word untouched"}, mem[idx], pre);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        size    = 2'b00;
        addr    = 32'h0;
        data_in = 32'h0;
        pokeEn  = 1'b0;
        pokeIdx = 6'h0;
        pokeVal = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ctrl", {28'h0, busy, mem_we, done, err}, 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 64; i++) poke(i, $urandom);

        //          s      a             d              pre            exp            e  lat hit poke
        tbl[0]  = '{2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 0, 2, 0, 1};
        tbl[1]  = '{2'b10, 32'h0000_0020, 32'hFFFF_FFAA, 32'h1122_3344, 32'h1122_33AA, 0, 4, 0, 1};
        tbl[2]  = '{2'b10, 32'h0000_0021, 32'hFFFF_FFAA, 32'h1122_3344, 32'h1122_AA44, 0, 4, 1, 1};
        tbl[3]  = '{2'b10, 32'h0000_0022, 32'hFFFF_FFAA, 32'h1122_3344, 32'h11AA_3344, 0, 4, 0, 1};
        tbl[4]  = '{2'b10, 32'h0000_0023, 32'hFFFF_FFAA, 32'h1122_3344, 32'hAA22_3344, 0, 4, 0, 1};
        tbl[5]  = '{2'b01, 32'h0000_0030, 32'h0000_BEEF, 32'h1122_3344, 32'h1122_BEEF, 0, 4, 0, 1};
        tbl[6]  = '{2'b01, 32'h0000_0032, 32'h0000_BEEF, 32'h1122_3344, 32'hBEEF_3344, 0, 4, 0, 1};
        tbl[7]  = '{2'b00, 32'h0000_0041, 32'h1234_5678, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 1, 0, 1};
        tbl[8]  = '{2'b01, 32'h0000_0043, 32'h1234_5678, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 1, 0, 0};
        tbl[9]  = '{2'b11, 32'h0000_0040, 32'h1234_5678, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 1, 0, 0};
        tbl[10] = '{2'b01, 32'h0000_0041, 32'h1234_5678, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 1, 0, 0};
        tbl[11] = '{2'b10, 32'h0000_0043, 32'h1234_5677, 32'hCAFE_F00D, 32'h77FE_F00D, 0, 4, 0, 0};
        tbl[12] = '{2'b00, 32'h0000_0044, 32'h0BAD_F00D, 32'h0000_0000, 32'h0BAD_F00D, 0, 2, 0, 0};
        tbl[13] = '{2'b01, 32'h0000_0002, 32'h0000_A5A5, 32'h0000_0000, 32'hA5A5_0000, 0, 4, 1, 1};
        tbl[14] = '{2'b00, 32'h0000_0008, 32'h600D_D00D, 32'hFFFF_FFFF, 32'h600D_D00D, 0, 2, 1, 1};

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].doPoke) poke(int'(tbl[i].a[7:2]), tbl[i].pre);
            applyAndCheck($sformatf("vec%0d", i), tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].hit,
                          tbl[i].exp, tbl[i].e, tbl[i].lat);
        end

        // Reset during READ of an sb, then a normal sw.
        resetMidOp("rstRead", 2'b10, 32'h0000_0061, 32'h0000_00AA, 32'h1122_3344, 1);
        applyAndCheck("swAfterRstRead", 2'b00, 32'h0000_0064, 32'h0BAD_CAFE, 1'b0,
                      32'h0BAD_CAFE, 1'b0, 2);

        // Reset during WRITE of an sw, then a normal sw.
        resetMidOp("rstWrite", 2'b00, 32'h0000_0068, 32'h1357_9BDF, 32'h2468_ACE0, 1);
        applyAndCheck("swAfterRstWrite", 2'b00, 32'h0000_0068, 32'h1357_9BDF, 1'b0,
                      32'h1357_9BDF, 1'b0, 2);

        // Randomized requests against the reference memory.
        for (int n = 0; n < 150; n++) begin
            logic [1:0]  s;
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] expWord;
            bit          bad;
            s   = 2'($urandom_range(0, 3));
            a   = 32'($urandom_range(0, 255));
            d   = $urandom;
            bad = refBad(s, a);
            expWord = bad ? refMem[a[7:2]] : refMerge(s, a, d, refMem[a[7:2]]);
            applyAndCheck($sformatf("rnd%0d", n), s, a, d, ($urandom_range(0, 3) == 0),
                          expWord, bad, refLat(s, a));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
